cache_req_gen: RTL and testbench

Hardware access-sequence generator that acts as the requesting side of the single-cycle read interface of `cache_4wayl2`. It issues strided read sequences over one or more passes and samples `hit`/`read_data` for every access. It accumulates hit/miss statistics for on-chip characterisation of replacement behaviour. It sits between a host/control register block and the cache read port, replacing hand-written bench stimulus in system-level runs.

---
 rtl/cache_req_pkg.sv | 15 +
 rtl/cache_stat_counter.sv | 34 +++
 rtl/cache_req_gen.sv | 186 ++++++++++++++++++
 tb/tb_cache_req_gen.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_req_pkg.sv
// Shared types and default widths for the cache access-sequence generator.
package cache_req_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 11;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cache_stat_counter.sv
// Saturating event counter with synchronous clear and enable.
module cache_stat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Clear wins over enable; the counter sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_req_gen.sv
// Strided read-sequence generator driving the cache read port and collecting hit/miss stats.
// Define CACHE_REQ_GEN_CHECKSUM_EN to build the XOR-over-hits checksum register.
module cache_req_gen
  import cache_req_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  num_access,
  input  logic [CNT_WIDTH-1:0]  num_pass,
  output logic                  req_read,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic [DATA_WIDTH-1:0] checksum
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  nacc_q, nacc_d;
  logic [CNT_WIDTH-1:0]  npass_q, npass_d;
  logic [CNT_WIDTH-1:0]  acc_idx_q, acc_idx_d;
  logic [CNT_WIDTH-1:0]  pass_idx_q, pass_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_read_q, req_read_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] last_data_q, last_data_d;

  logic launch_c;
  logic sample_c;
  logic last_acc_c;
  logic last_pass_c;

  assign launch_c    = start && ((state_q == IDLE) || (state_q == DONE));
  assign sample_c    = (state_q == WAIT);
  assign last_acc_c  = (acc_idx_q == (nacc_q - CNT_WIDTH'(1)));
  assign last_pass_c = (pass_idx_q == (npass_q - CNT_WIDTH'(1)));

  // Next-state and datapath updates; output flops follow the next state.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    stride_d    = stride_q;
    nacc_d      = nacc_q;
    npass_d     = npass_q;
    acc_idx_d   = acc_idx_q;
    pass_idx_d  = pass_idx_q;
    addr_d      = addr_q;
    last_data_d = last_data_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          base_d      = base_addr;
          stride_d    = stride;
          nacc_d      = num_access;
          npass_d     = (num_pass == '0) ? CNT_WIDTH'(1) : num_pass;
          acc_idx_d   = '0;
          pass_idx_d  = '0;
          addr_d      = base_addr;
          last_data_d = '0;
          state_d     = (num_access == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        last_data_d = cache_data;
        if (last_acc_c) begin
          acc_idx_d = '0;
          if (last_pass_c) begin
            state_d = DONE;
          end else begin
            pass_idx_d = pass_idx_q + CNT_WIDTH'(1);
            addr_d     = base_q;
            state_d    = ISSUE;
          end
        end else begin
          acc_idx_d = acc_idx_q + CNT_WIDTH'(1);
          addr_d    = addr_q + stride_q;
          state_d   = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_read_d = (state_d == ISSUE);
    busy_d     = (state_d == ISSUE) || (state_d == WAIT);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      stride_q    <= '0;
      nacc_q      <= '0;
      npass_q     <= '0;
      acc_idx_q   <= '0;
      pass_idx_q  <= '0;
      addr_q      <= '0;
      req_read_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      nacc_q      <= nacc_d;
      npass_q     <= npass_d;
      acc_idx_q   <= acc_idx_d;
      pass_idx_q  <= pass_idx_d;
      addr_q      <= addr_d;
      req_read_q  <= req_read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      last_data_q <= last_data_d;
    end
  end

  cache_stat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (launch_c),
    .en    (sample_c && cache_hit),
    .count (hit_count)
  );

  cache_stat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (launch_c),
    .en    (sample_c && !cache_hit),
    .count (miss_count)
  );

`ifdef CACHE_REQ_GEN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // Only hit data folds into the checksum.
  always_comb begin
    checksum_d = checksum_q;
    if (launch_c) begin
      checksum_d = '0;
    end else if (sample_c && cache_hit) begin
      checksum_d = checksum_q ^ cache_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign req_read  = req_read_q;
  assign req_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign last_data = last_data_q;

endmodule

// File: tb/tb_cache_req_gen.sv
// Bench for cache_req_gen: a cold-start infinite cache responder, a run-level reference model and per-cycle checks.
module tb_cache_req_gen;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] num_access = '0;
  logic [CW-1:0] num_pass = '0;
  logic          req_read;
  logic [AW-1:0] req_addr;
  logic          cache_hit = 1'b0;
  logic [DW-1:0] cache_data = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [DW-1:0] last_data;
  logic [DW-1:0] checksum;

  cache_req_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .stride     (stride),
    .num_access (num_access),
    .num_pass   (num_pass),
    .req_read   (req_read),
    .req_addr   (req_addr),
    .cache_hit  (cache_hit),
    .cache_data (cache_data),
    .busy       (busy),
    .done       (done),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .last_data  (last_data),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache responder: first touch of an address misses, later touches hit; a script queue overrides.
  bit            seen [int];
  logic          script_hit  [$];
  logic [DW-1:0] script_data [$];
  logic          log_hit     [$];
  logic [DW-1:0] log_data    [$];
  logic [AW-1:0] addr_log    [$];

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ (DW'(a) * 32'h0001_0003);
  endfunction

  always @(negedge clk) begin
    if (rst && req_read) begin
      logic          h;
      logic [DW-1:0] d;
      if (script_hit.size() > 0) begin
        h = script_hit.pop_front();
        d = script_data.pop_front();
      end else begin
        h = seen.exists(int'(req_addr));
        seen[int'(req_addr)] = 1'b1;
        d = data_of(req_addr);
      end
      cache_hit  = h;
      cache_data = d;
      log_hit.push_back(h);
      log_data.push_back(d);
      addr_log.push_back(req_addr);
    end
  end

  // Run model: m_c counts edges since the accepted start; a run lasts 2*N*P edges.
  bit            m_run = 1'b0;
  int            m_c = 0;
  int            m_total = 0;
  logic [AW-1:0] m_addr [$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run   = 1'b0;
      m_c     = 0;
      m_total = 0;
      m_addr.delete();
    end else if (start && (!m_run || m_c >= m_total)) begin
      int np;
      np = (num_pass == '0) ? 1 : int'(num_pass);
      m_addr.delete();
      for (int p = 0; p < np; p++)
        for (int i = 0; i < int'(num_access); i++)
          m_addr.push_back(AW'(int'(base_addr) + i * int'(stride)));
      m_total = 2 * int'(num_access) * np;
      m_c     = 0;
      m_run   = 1'b1;
      log_hit.delete();
      log_data.delete();
    end else if (m_run && m_c < m_total) begin
      m_c++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      logic          e_busy, e_done, e_rr;
      int            comp, eh, em;
      logic [DW-1:0] eld, ecs;
      e_busy = 1'b0; e_done = 1'b0; e_rr = 1'b0;
      comp = 0; eh = 0; em = 0; eld = '0; ecs = '0;
      if (m_run) begin
        e_busy = (m_c < m_total);
        e_done = !e_busy;
        e_rr   = e_busy && (m_c % 2 == 0);
        comp   = e_busy ? m_c / 2 : m_total / 2;
        for (int j = 0; j < comp && j < log_hit.size(); j++) begin
          if (log_hit[j]) begin
            eh++;
            ecs = ecs ^ log_data[j];
          end else begin
            em++;
          end
        end
        if (comp > 0 && comp <= log_data.size()) eld = log_data[comp-1];
      end
      if (eh > SAT) eh = SAT;
      if (em > SAT) em = SAT;
`ifndef CACHE_REQ_GEN_CHECKSUM_EN
      ecs = '0;
`endif
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("req_read", 64'(req_read), 64'(e_rr));
      if (e_busy) chk("req_addr", 64'(req_addr), 64'(m_addr[m_c/2]));
      else if (!m_run) chk("req_addr_idle", 64'(req_addr), 64'd0);
      chk("hit_count", 64'(hit_count), 64'(eh));
      chk("miss_count", 64'(miss_count), 64'(em));
      chk("last_data", 64'(last_data), 64'(eld));
      chk("checksum", 64'(checksum), 64'(ecs));
    end
  end

  int t_launch;

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input logic [CW-1:0] n, input logic [CW-1:0] p);
    @(negedge clk);
    base_addr  = b;
    stride     = s;
    num_access = n;
    num_pass   = p;
    start      = 1'b1;
    @(posedge clk);
    #1;
    t_launch = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int t_done);
    t_done = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        t_done = cyc;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: done never rose within 400 cycles", name);
  endtask

  initial begin
    int t_done;
    int ok;
    logic [AW-1:0] wrap_exp [3];

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_read", 64'(req_read), 64'd0);
    chk("rst_req_addr", 64'(req_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hits", 64'(hit_count), 64'd0);
    chk("rst_misses", 64'(miss_count), 64'd0);
    chk("rst_last_data", 64'(last_data), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Cold cache, two passes of eight
    seen.delete(); addr_log.delete();
    launch(11'h000, 11'h020, 4'd8, 4'd2);
    wait_done("t1_done", t_done);
    chk("t1_done_latency", 64'(t_done - t_launch), 64'd32);
    chk("t1_hits", 64'(hit_count), 64'd8);
    chk("t1_misses", 64'(miss_count), 64'd8);
    chk("t1_reads", 64'(addr_log.size()), 64'd16);
    ok = 1;
    for (int k = 0; k < addr_log.size(); k++)
      if (addr_log[k] !== AW'((k % 8) * 32)) ok = 0;
    chk("t1_addr_seq", 64'(ok), 64'd1);

    // Address wrap-around
    seen.delete(); addr_log.delete();
    launch(11'h7E0, 11'h020, 4'd3, 4'd1);
    wait_done("t2_done", t_done);
    wrap_exp[0] = 11'h7E0; wrap_exp[1] = 11'h000; wrap_exp[2] = 11'h020;
    chk("t2_reads", 64'(addr_log.size()), 64'd3);
    for (int k = 0; k < 3 && k < addr_log.size(); k++)
      chk("t2_wrap_addr", 64'(addr_log[k]), 64'(wrap_exp[k]));
    chk("t2_misses", 64'(miss_count), 64'd3);

    // Zero accesses: straight to done, counters cleared
    addr_log.delete();
    launch(11'h123, 11'h001, 4'd0, 4'd1);
    chk("t3_done_next", 64'(done), 64'd1);
    chk("t3_req_read", 64'(req_read), 64'd0);
    chk("t3_misses", 64'(miss_count), 64'd0);
    repeat (4) @(negedge clk);
    chk("t3_no_reads", 64'(addr_log.size()), 64'd0);

    // start pulse mid-run is ignored
    seen.delete(); addr_log.delete();
    launch(11'h100, 11'h010, 4'd8, 4'd1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (addr_log.size() >= 3) break;
    end
    @(negedge clk);
    base_addr = 11'h555;
    stride    = 11'h003;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_done", t_done);
    chk("t4_reads", 64'(addr_log.size()), 64'd8);
    ok = 1;
    for (int k = 0; k < addr_log.size(); k++)
      if (addr_log[k] !== AW'(32'h100 + k * 16)) ok = 0;
    chk("t4_addr_seq", 64'(ok), 64'd1);

    // Reset during WAIT of access 4 (addresses already cached, so all hits)
    addr_log.delete();
    launch(11'h100, 11'h010, 4'd8, 4'd1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (addr_log.size() >= 4 && !req_read) break;
    end
    chk("t5_hits_before_rst", 64'(hit_count), 64'd3);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_req_read", 64'(req_read), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_hits", 64'(hit_count), 64'd0);
    chk("t5_rst_req_addr", 64'(req_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen.delete(); addr_log.delete();
    launch(11'h200, 11'h004, 4'd5, 4'd1);
    wait_done("t5_rerun_done", t_done);
    chk("t5_rerun_misses", 64'(miss_count), 64'd5);
    chk("t5_rerun_hits", 64'(hit_count), 64'd0);
    chk("t5_rerun_first_addr", 64'(addr_log[0]), 64'h200);

    // num_pass = 0 behaves as one pass
    seen.delete(); addr_log.delete();
    launch(11'h040, 11'h001, 4'd3, 4'd0);
    wait_done("t6_done", t_done);
    chk("t6_reads", 64'(addr_log.size()), 64'd3);
    chk("t6_latency", 64'(t_done - t_launch), 64'd6);

    // Same address 18 times: 1 miss, 17 hits saturating at 15
    seen.delete(); addr_log.delete();
    launch(11'h300, 11'h000, 4'd9, 4'd2);
    wait_done("t7_done", t_done);
    chk("t7_hits_sat", 64'(hit_count), 64'd15);
    chk("t7_misses", 64'(miss_count), 64'd1);

    // Checksum over hits only
    script_hit.push_back(1'b1); script_data.push_back(32'h0000_00FF);
    script_hit.push_back(1'b1); script_data.push_back(32'h0000_0F0F);
    script_hit.push_back(1'b0); script_data.push_back(32'h1234_5678);
    launch(11'h010, 11'h001, 4'd3, 4'd1);
    wait_done("t8_done", t_done);
    chk("t8_hits", 64'(hit_count), 64'd2);
    chk("t8_misses", 64'(miss_count), 64'd1);
    chk("t8_last_data", 64'(last_data), 64'h1234_5678);
`ifdef CACHE_REQ_GEN_CHECKSUM_EN
    chk("t8_checksum", 64'(checksum), 64'h0000_0FF0);
`else
    chk("t8_checksum", 64'(checksum), 64'h0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
